// File: rtl/mac_relu_unit.sv
// mac_relu_unit: two-stage signed multiply-accumulate with optional saturation and ReLU output
module mac_relu_unit #(
  parameter int DATA_W = 32,
  parameter int ACC_W = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  relu_acc,
  output logic              busy,
  output logic              ovf
);
  localparam int PW = 2 * DATA_W;
  localparam int SW = (PW > ACC_W ? PW : ACC_W) + 1;
  logic signed [PW-1:0] prod_r;
  logic prod_v;
  logic signed [SW-1:0] sum;
  logic [SW-ACC_W:0] top;
  logic in_range;
  logic [ACC_W-1:0] nxt;
  always_comb begin
    sum = SW'($signed(acc)) + SW'(prod_r);
    top = sum[SW-1:ACC_W-1];
    in_range = &top | ~|top;
    nxt = (in_range || !SATURATE) ? sum[ACC_W-1:0] : {sum[SW-1], {(ACC_W-1){~sum[SW-1]}}};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r <= '0;
      prod_v <= 1'b0;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      prod_r <= PW'($signed(a)) * PW'($signed(b));
      prod_v <= enable & ~clear;
      if (clear) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (prod_v) begin
        acc <= nxt;
        ovf <= ovf | ~in_range;
      end
    end
  end
  assign relu_acc = acc[ACC_W-1] ? '0 : acc;
  assign busy = prod_v;
endmodule

// File: tb/tb_mac_relu_unit.sv
// tb_mac_relu_unit: scoreboard bench for wrapping and saturating MAC instances
module tb_mac_relu_unit;
  logic clk = 1'b0;
  logic rst, clear, enable;
  logic [31:0] a, b;
  logic [31:0] acc_w, relu_w, acc_s, relu_s;
  logic busy_w, ovf_w, busy_s, ovf_s;
  int total = 0;
  int bad = 0;
  int pa[9];
  int pb[9];
  typedef struct {int w; int s; bit ow; bit os;} exp_t;
  exp_t sb[$];
  localparam longint MAX = 64'sd2147483647;
  localparam longint MIN = -64'sd2147483648;

  always #5 clk = ~clk;

  mac_relu_unit #(.DATA_W(32), .ACC_W(32), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .a(a), .b(b),
    .acc(acc_w), .relu_acc(relu_w), .busy(busy_w), .ovf(ovf_w)
  );
  mac_relu_unit #(.DATA_W(32), .ACC_W(32), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .a(a), .b(b),
    .acc(acc_s), .relu_acc(relu_s), .busy(busy_s), .ovf(ovf_s)
  );

  task automatic cyc(input bit r, input bit c, input bit e, input int x, input int y);
    rst = r;
    clear = c;
    enable = e;
    a = x;
    b = y;
    @(negedge clk);
  endtask

  task automatic feed(input bit do_clr, input int n);
    longint w = 0, s = 0, p;
    exp_t e;
    e.ow = 1'b0;
    e.os = 1'b0;
    if (do_clr) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 1, pa[i], pb[i]);
      p = longint'(pa[i]) * longint'(pb[i]);
      w = w + p;
      if (w > MAX || w < MIN) e.ow = 1'b1;
      w = longint'(int'(w));
      s = s + p;
      if (s > MAX) begin s = MAX; e.os = 1'b1; end
      else if (s < MIN) begin s = MIN; e.os = 1'b1; end
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    e.w = int'(w);
    e.s = int'(s);
    sb.push_back(e);
  endtask

  task automatic test_reset;
    cyc(1, 0, 1, 5, 5);
    cyc(0, 0, 0, 0, 0);
    total++; if (acc_w !== 32'd0) begin bad++; $display("FAIL reset_acc got=%0h exp=0", acc_w); end
    total++; if (relu_w !== 32'd0) begin bad++; $display("FAIL reset_relu got=%0h exp=0", relu_w); end
    total++; if (ovf_w !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf_w); end
    total++; if (busy_w !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy_w); end
    total++; if (acc_s !== 32'd0) begin bad++; $display("FAIL reset_acc_sat got=%0h exp=0", acc_s); end
  endtask

  task automatic test_single;
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 7, -3);
    total++; if (busy_w !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b exp=1", busy_w); end
    total++; if (acc_w !== 32'd0) begin bad++; $display("FAIL single_early got=%0h exp=0", acc_w); end
    cyc(0, 0, 0, 0, 0);
    total++; if ($signed(acc_w) !== -21) begin bad++; $display("FAIL single_acc got=%0d exp=-21", $signed(acc_w)); end
    total++; if (relu_w !== 32'd0) begin bad++; $display("FAIL single_relu got=%0h exp=0", relu_w); end
    total++; if (busy_w !== 1'b0) begin bad++; $display("FAIL single_busy_done got=%0b exp=0", busy_w); end
  endtask

  task automatic test_window(input bit rev);
    exp_t e;
    pb = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 9; i++) pa[i] = rev ? 9 - i : i + 1;
    feed(1'b1, 9);
    e = sb.pop_front();
    total++; if ($signed(acc_w) !== e.w) begin bad++; $display("FAIL window%0d_acc got=%0d exp=%0d", rev, $signed(acc_w), e.w); end
    total++; if ($signed(relu_w) !== (e.w < 0 ? 0 : e.w)) begin bad++; $display("FAIL window%0d_relu got=%0d exp=%0d", rev, $signed(relu_w), e.w < 0 ? 0 : e.w); end
    total++; if ($signed(acc_s) !== e.s) begin bad++; $display("FAIL window%0d_acc_sat got=%0d exp=%0d", rev, $signed(acc_s), e.s); end
    total++; if (ovf_w !== e.ow) begin bad++; $display("FAIL window%0d_ovf got=%0b exp=%0b", rev, ovf_w, e.ow); end
  endtask

  task automatic test_wrap_sat;
    exp_t e;
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 32'h40000000, 2);
    cyc(0, 0, 1, 32'h40000000, 2);
    total++; if (acc_w !== 32'h80000000) begin bad++; $display("FAIL wrap_mid_acc got=%0h exp=80000000", acc_w); end
    total++; if (relu_w !== 32'd0) begin bad++; $display("FAIL wrap_mid_relu got=%0h exp=0", relu_w); end
    total++; if (ovf_w !== 1'b1) begin bad++; $display("FAIL wrap_mid_ovf got=%0b exp=1", ovf_w); end
    total++; if (acc_s !== 32'h7FFFFFFF) begin bad++; $display("FAIL sat_mid_acc got=%0h exp=7fffffff", acc_s); end
    cyc(0, 0, 0, 0, 0);
    total++; if (acc_w !== 32'h0) begin bad++; $display("FAIL wrap_acc got=%0h exp=0", acc_w); end
    total++; if (ovf_w !== 1'b1) begin bad++; $display("FAIL wrap_ovf got=%0b exp=1", ovf_w); end
    total++; if (acc_s !== 32'h7FFFFFFF) begin bad++; $display("FAIL sat_acc got=%0h exp=7fffffff", acc_s); end
    total++; if (relu_s !== 32'h7FFFFFFF) begin bad++; $display("FAIL sat_relu got=%0h exp=7fffffff", relu_s); end
    total++; if (ovf_s !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%0b exp=1", ovf_s); end
    pa[0] = 32'h40000000; pb[0] = 2;
    pa[1] = 32'h40000000; pb[1] = 2;
    pa[2] = -5; pb[2] = 3;
    feed(1'b1, 3);
    e = sb.pop_front();
    total++; if ($signed(acc_w) !== e.w) begin bad++; $display("FAIL wrap_model_acc got=%0d exp=%0d", $signed(acc_w), e.w); end
    total++; if ($signed(acc_s) !== e.s) begin bad++; $display("FAIL sat_model_acc got=%0d exp=%0d", $signed(acc_s), e.s); end
    total++; if (ovf_s !== e.os) begin bad++; $display("FAIL sat_model_ovf got=%0b exp=%0b", ovf_s, e.os); end
  endtask

  task automatic test_rst_mid;
    exp_t e;
    cyc(0, 0, 1, 3, 3);
    cyc(1, 0, 1, 9, 9);
    total++; if (acc_w !== 32'd0) begin bad++; $display("FAIL rstmid_acc got=%0h exp=0", acc_w); end
    total++; if (busy_w !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", busy_w); end
    total++; if (ovf_w !== 1'b0) begin bad++; $display("FAIL rstmid_ovf got=%0b exp=0", ovf_w); end
    total++; if (ovf_s !== 1'b0) begin bad++; $display("FAIL rstmid_ovf_sat got=%0b exp=0", ovf_s); end
    cyc(0, 0, 0, 0, 0);
    total++; if (acc_w !== 32'd0) begin bad++; $display("FAIL rstmid_hold got=%0h exp=0", acc_w); end
    pa[0] = 3; pb[0] = 4;
    pa[1] = -2; pb[1] = 5;
    feed(1'b0, 2);
    e = sb.pop_front();
    total++; if ($signed(acc_w) !== e.w) begin bad++; $display("FAIL rstmid_resume got=%0d exp=%0d", $signed(acc_w), e.w); end
    total++; if ($signed(acc_s) !== e.s) begin bad++; $display("FAIL rstmid_resume_sat got=%0d exp=%0d", $signed(acc_s), e.s); end
  endtask

  task automatic test_clear_mid;
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 5, 5);
    cyc(0, 0, 0, 0, 0);
    total++; if (acc_w !== 32'd25) begin bad++; $display("FAIL clrmid_pre got=%0d exp=25", acc_w); end
    cyc(0, 0, 1, 7, 7);
    cyc(0, 1, 1, 4, 4);
    total++; if (acc_w !== 32'd0) begin bad++; $display("FAIL clrmid_acc got=%0d exp=0", acc_w); end
    total++; if (busy_w !== 1'b0) begin bad++; $display("FAIL clrmid_busy got=%0b exp=0", busy_w); end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    total++; if (acc_w !== 32'd0) begin bad++; $display("FAIL clrmid_stay got=%0d exp=0", acc_w); end
    cyc(0, 0, 1, 2, 3);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    total++; if (acc_w !== 32'd6) begin bad++; $display("FAIL clrmid_next got=%0d exp=6", acc_w); end
    total++; if (relu_s !== 32'd6) begin bad++; $display("FAIL clrmid_relu_sat got=%0d exp=6", relu_s); end
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    enable = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    test_reset;
    test_single;
    test_window(1'b0);
    test_window(1'b1);
    test_wrap_sat;
    test_rst_mid;
    test_clear_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
